iic_slave: RTL

I2C/SCCB responder with a 16-bit register address and a small internal register file, written in the OV5640 camera's register style. It is the far end of the I2C master on the camera configuration path. It serves as a camera stand-in in system simulation and as an on-chip register target. It decodes START/STOP, matches a 7-bit device address, accepts 16-bit register addresses, and handles burst writes and burst reads with auto-increment. It drives SDA open-drain.

---
 rtl/iic_slave.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/iic_slave.sv
// I2C/SCCB register responder: 7-bit device address, 16-bit register
// pointer, burst write/read with auto-increment, open-drain SDA drive.
module iic_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h3C,
  parameter int          MEM_AW   = 8
) (
  input  logic        clk_4x,
  input  logic        rst,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic        busy,
  output logic        wr_strobe,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data
);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_DEV        = 4'd1;
  localparam logic [3:0] S_DEV_ACK    = 4'd2;
  localparam logic [3:0] S_ADDR_H     = 4'd3;
  localparam logic [3:0] S_ADDR_H_ACK = 4'd4;
  localparam logic [3:0] S_ADDR_L     = 4'd5;
  localparam logic [3:0] S_ADDR_L_ACK = 4'd6;
  localparam logic [3:0] S_WR_DATA    = 4'd7;
  localparam logic [3:0] S_WR_ACK     = 4'd8;
  localparam logic [3:0] S_RD_DATA    = 4'd9;
  localparam logic [3:0] S_RD_ACK     = 4'd10;
  localparam logic [3:0] S_WAIT       = 4'd11;

  // [1:0] synchronizer, [2] previous synchronized value
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  logic [3:0]  state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  logic [7:0]  sr_q, sr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        rw_q, rw_d;
  logic        oe_q, oe_d;
  logic        stb_q, stb_d;
  logic [15:0] wa_q, wa_d;
  logic [7:0]  wd_q, wd_d;
  logic        we;

  logic [7:0] mem_q [2**MEM_AW];

  logic       sda_s;
  logic       rise, fall, start, stop;
  logic       last;
  logic [7:0] sh;
  logic [7:0] rd_b;

  assign sda_s = sda_q[1];
  assign rise  = scl_q[1] & ~scl_q[2];
  assign fall  = ~scl_q[1] & scl_q[2];
  assign start = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop  = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
  assign last  = (cnt_q == 3'd7);
  assign sh    = {sr_q[6:0], sda_s};
  assign rd_b  = mem_q[ptr_q[MEM_AW-1:0]];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    oe_d    = oe_q;
    stb_d   = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    we      = 1'b0;
    if (stop) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
    end else if (start) begin
      state_d = S_DEV;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
    end else if (rise) begin
      cnt_d = cnt_q + 3'd1;
      sr_d  = sh;
      unique case (state_q)
        S_DEV: if (last) begin
          if (sh[7:1] != DEV_ADDR) begin
            state_d = S_WAIT;
          end else begin
            rw_d    = sh[0];
            state_d = S_DEV_ACK;
          end
        end
        S_ADDR_H: if (last) begin
          ptr_d[15:8] = sh;
          state_d     = S_ADDR_H_ACK;
        end
        S_ADDR_L: if (last) begin
          ptr_d[7:0] = sh;
          state_d    = S_ADDR_L_ACK;
        end
        S_WR_DATA: if (last) begin
          we      = 1'b1;
          stb_d   = 1'b1;
          wa_d    = ptr_q;
          wd_d    = sh;
          ptr_d   = ptr_q + 16'd1;
          state_d = S_WR_ACK;
        end
        S_RD_DATA: if (last) begin
          ptr_d   = ptr_q + 16'd1;
          state_d = S_RD_ACK;
        end
        S_RD_ACK: if (sda_s) begin
          oe_d    = 1'b0;
          state_d = S_WAIT;
        end
        default: ;
      endcase
    end else if (fall) begin
      unique case (state_q)
        S_DEV_ACK, S_ADDR_H_ACK, S_ADDR_L_ACK, S_WR_ACK: begin
          // cnt 0: first fall after the byte, cnt 1: end of the 9th clock
          if (cnt_q == 3'd0) begin
            oe_d = 1'b1;
          end else if (state_q == S_DEV_ACK && rw_q) begin
            sr_d    = rd_b;
            oe_d    = ~rd_b[7];
            cnt_d   = 3'd0;
            state_d = S_RD_DATA;
          end else begin
            oe_d  = 1'b0;
            cnt_d = 3'd0;
            if (state_q == S_DEV_ACK)
              state_d = S_ADDR_H;
            else if (state_q == S_ADDR_H_ACK)
              state_d = S_ADDR_L;
            else
              state_d = S_WR_DATA;
          end
        end
        S_RD_DATA: oe_d = ~sr_q[7];
        S_RD_ACK: begin
          if (cnt_q == 3'd0) begin
            oe_d = 1'b0;
          end else begin
            sr_d    = rd_b;
            oe_d    = ~rd_b[7];
            cnt_d   = 3'd0;
            state_d = S_RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_4x or negedge rst) begin
    if (!rst) begin
      scl_q   <= 3'b111;
      sda_q   <= 3'b111;
      state_q <= S_IDLE;
      ptr_q   <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      oe_q    <= 1'b0;
      stb_q   <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      scl_q   <= {scl_q[1:0], scl};
      sda_q   <= {sda_q[1:0], sda_in};
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      oe_q    <= oe_d;
      stb_q   <= stb_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
    end
  end

  always_ff @(posedge clk_4x or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2**MEM_AW; i++)
        mem_q[i] <= '0;
    end else if (we) begin
      mem_q[ptr_q[MEM_AW-1:0]] <= sh;
    end
  end

  assign sda_oe    = oe_q;
  assign busy      = (state_q != S_IDLE);
  assign wr_strobe = stb_q;
  assign wr_addr   = wa_q;
  assign wr_data   = wd_q;

endmodule
